// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// AXI-lite channel bundle shared by the arbiter's two upstream ports and its downstream port.
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master AXI-lite arbiter (m0 = IFU, m1 = LSU), one whole transaction granted at a time.
// Define ARB_LSU_PRIORITY_EN to make m1 win every tie instead of round-robin.
module ysyx_24110015_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       rst,
    axi_lite_if.slave m0,
    axi_lite_if.slave m1,
    axi_lite_if.master s
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t state_r, state_s;
    logic gnt_r, gnt_s, last_r, last_s;
    logic aw_done_r, aw_done_s, w_done_r, w_done_s;
    logic req0_s, req1_s, win_s, win_ar_s;
    logic aw_fire_s, w_fire_s;

    logic              g_arvalid_s, g_rready_s, g_awvalid_s, g_wvalid_s, g_bready_s;
    logic [ADDR_W-1:0] g_araddr_s, g_awaddr_s;
    logic [DATA_W-1:0] g_wdata_s;
    logic [STRB_W-1:0] g_wstrb_s;

    logic              u_arready_s, u_rvalid_s, u_awready_s, u_wready_s, u_bvalid_s;
    logic [DATA_W-1:0] u_rdata_s;
    logic [1:0]        u_rresp_s, u_bresp_s;

    assign req0_s = m0.arvalid | m0.awvalid;
    assign req1_s = m1.arvalid | m1.awvalid;

    // request side of whichever master currently holds the grant
    always_comb begin
        if (gnt_r) begin
            g_arvalid_s = m1.arvalid;  g_araddr_s = m1.araddr;  g_rready_s = m1.rready;
            g_awvalid_s = m1.awvalid;  g_awaddr_s = m1.awaddr;  g_wvalid_s = m1.wvalid;
            g_wdata_s   = m1.wdata;    g_wstrb_s  = m1.wstrb;   g_bready_s = m1.bready;
        end else begin
            g_arvalid_s = m0.arvalid;  g_araddr_s = m0.araddr;  g_rready_s = m0.rready;
            g_awvalid_s = m0.awvalid;  g_awaddr_s = m0.awaddr;  g_wvalid_s = m0.wvalid;
            g_wdata_s   = m0.wdata;    g_wstrb_s  = m0.wstrb;   g_bready_s = m0.bready;
        end
    end

    // arbitration winner; only consulted in IDLE when at least one master requests
    always_comb begin
`ifdef ARB_LSU_PRIORITY_EN
        win_s = req1_s;
`else
        if (req0_s & req1_s) begin
            win_s = ~last_r;
        end else begin
            win_s = req1_s;
        end
`endif
        if (win_s) begin
            win_ar_s = m1.arvalid;
        end else begin
            win_ar_s = m0.arvalid;
        end
    end

    assign aw_fire_s = (state_r == WR_ADDR) & g_awvalid_s & ~aw_done_r & s.awready;
    assign w_fire_s  = (state_r == WR_ADDR) & g_wvalid_s & ~w_done_r & s.wready;

    // next-state and grant bookkeeping
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        last_s    = last_r;
        aw_done_s = aw_done_r;
        w_done_s  = w_done_r;
        case (state_r)
            IDLE: begin
                if (req0_s | req1_s) begin
                    gnt_s   = win_s;
                    last_s  = win_s;
                    state_s = win_ar_s ? RD_ADDR : WR_ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (g_arvalid_s & s.arready) state_s = RD_DATA;
                else                         state_s = RD_ADDR;
            end
            RD_DATA: begin
                if (s.rvalid & g_rready_s) state_s = IDLE;
                else                       state_s = RD_DATA;
            end
            WR_ADDR: begin
                // both channels done (possibly in the same cycle) closes the address phase
                if ((aw_done_r | aw_fire_s) & (w_done_r | w_fire_s)) begin
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                    state_s   = WR_RESP;
                end else begin
                    aw_done_s = aw_done_r | aw_fire_s;
                    w_done_s  = w_done_r | w_fire_s;
                end
            end
            WR_RESP: begin
                if (s.bvalid & g_bready_s) state_s = IDLE;
                else                       state_s = WR_RESP;
            end
            default: begin
                state_s   = IDLE;
                aw_done_s = 1'b0;
                w_done_s  = 1'b0;
            end
        endcase
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt_r     <= 1'b0;
            last_r    <= 1'b1;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            last_r    <= last_s;
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
        end
    end

    // downstream forwarding and the granted master's response side
    always_comb begin
        s.araddr = {ADDR_W{1'b0}}; s.arvalid = 1'b0; s.rready = 1'b0;
        s.awaddr = {ADDR_W{1'b0}}; s.awvalid = 1'b0;
        s.wdata  = {DATA_W{1'b0}}; s.wstrb = {STRB_W{1'b0}}; s.wvalid = 1'b0;
        s.bready = 1'b0;
        u_arready_s = 1'b0; u_rvalid_s = 1'b0; u_rdata_s = {DATA_W{1'b0}}; u_rresp_s = 2'b00;
        u_awready_s = 1'b0; u_wready_s = 1'b0; u_bvalid_s = 1'b0; u_bresp_s = 2'b00;
        case (state_r)
            RD_ADDR: begin
                s.araddr = g_araddr_s; s.arvalid = g_arvalid_s; u_arready_s = s.arready;
            end
            RD_DATA: begin
                s.rready = g_rready_s; u_rvalid_s = s.rvalid;
                u_rdata_s = s.rdata;   u_rresp_s = s.rresp;
            end
            WR_ADDR: begin
                s.awaddr = g_awaddr_s; s.awvalid = g_awvalid_s & ~aw_done_r;
                u_awready_s = s.awready & ~aw_done_r;
                s.wdata = g_wdata_s; s.wstrb = g_wstrb_s; s.wvalid = g_wvalid_s & ~w_done_r;
                u_wready_s = s.wready & ~w_done_r;
            end
            WR_RESP: begin
                s.bready = g_bready_s; u_bvalid_s = s.bvalid; u_bresp_s = s.bresp;
            end
            default: begin
                s.arvalid = 1'b0;
            end
        endcase
    end

    // route responses to the owner only; the other master sees all zeros
    always_comb begin
        m0.arready = 1'b0; m0.rvalid = 1'b0; m0.rdata = {DATA_W{1'b0}}; m0.rresp = 2'b00;
        m0.awready = 1'b0; m0.wready = 1'b0; m0.bvalid = 1'b0; m0.bresp = 2'b00;
        m1.arready = 1'b0; m1.rvalid = 1'b0; m1.rdata = {DATA_W{1'b0}}; m1.rresp = 2'b00;
        m1.awready = 1'b0; m1.wready = 1'b0; m1.bvalid = 1'b0; m1.bresp = 2'b00;
        if (gnt_r) begin
            m1.arready = u_arready_s; m1.rvalid = u_rvalid_s; m1.rdata = u_rdata_s; m1.rresp = u_rresp_s;
            m1.awready = u_awready_s; m1.wready = u_wready_s; m1.bvalid = u_bvalid_s; m1.bresp = u_bresp_s;
        end else begin
            m0.arready = u_arready_s; m0.rvalid = u_rvalid_s; m0.rdata = u_rdata_s; m0.rresp = u_rresp_s;
            m0.awready = u_awready_s; m0.wready = u_wready_s; m0.bvalid = u_bvalid_s; m0.bresp = u_bresp_s;
        end
    end
endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Bench for ysyx_24110015_axi_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level model of the arbiter.
module tb_ysyx_24110015_axi_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    ysyx_24110015_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // master-side stimulus and observations, indexed by master number
    logic        mst_arvalid [2], mst_awvalid [2], mst_wvalid [2], mst_rready [2], mst_bready [2];
    logic [31:0] mst_araddr [2], mst_awaddr [2], mst_wdata [2];
    logic [3:0]  mst_wstrb [2];
    logic        mo_arready [2], mo_rvalid [2], mo_awready [2], mo_wready [2], mo_bvalid [2];
    logic [31:0] mo_rdata [2];
    logic [1:0]  mo_rresp [2], mo_bresp [2];
    // slave-side stimulus and observations
    logic        slv_arready, slv_rvalid, slv_awready, slv_wready, slv_bvalid;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_rresp, slv_bresp;
    logic [31:0] so_araddr, so_awaddr, so_wdata;
    logic [3:0]  so_wstrb;
    logic        so_arvalid, so_rready, so_awvalid, so_wvalid, so_bready;

    assign m0_if.arvalid = mst_arvalid[0]; assign m1_if.arvalid = mst_arvalid[1];
    assign m0_if.araddr  = mst_araddr[0];  assign m1_if.araddr  = mst_araddr[1];
    assign m0_if.rready  = mst_rready[0];  assign m1_if.rready  = mst_rready[1];
    assign m0_if.awvalid = mst_awvalid[0]; assign m1_if.awvalid = mst_awvalid[1];
    assign m0_if.awaddr  = mst_awaddr[0];  assign m1_if.awaddr  = mst_awaddr[1];
    assign m0_if.wvalid  = mst_wvalid[0];  assign m1_if.wvalid  = mst_wvalid[1];
    assign m0_if.wdata   = mst_wdata[0];   assign m1_if.wdata   = mst_wdata[1];
    assign m0_if.wstrb   = mst_wstrb[0];   assign m1_if.wstrb   = mst_wstrb[1];
    assign m0_if.bready  = mst_bready[0];  assign m1_if.bready  = mst_bready[1];
    assign mo_arready[0] = m0_if.arready;  assign mo_arready[1] = m1_if.arready;
    assign mo_rvalid[0]  = m0_if.rvalid;   assign mo_rvalid[1]  = m1_if.rvalid;
    assign mo_rdata[0]   = m0_if.rdata;    assign mo_rdata[1]   = m1_if.rdata;
    assign mo_rresp[0]   = m0_if.rresp;    assign mo_rresp[1]   = m1_if.rresp;
    assign mo_awready[0] = m0_if.awready;  assign mo_awready[1] = m1_if.awready;
    assign mo_wready[0]  = m0_if.wready;   assign mo_wready[1]  = m1_if.wready;
    assign mo_bvalid[0]  = m0_if.bvalid;   assign mo_bvalid[1]  = m1_if.bvalid;
    assign mo_bresp[0]   = m0_if.bresp;    assign mo_bresp[1]   = m1_if.bresp;

    assign s_if.arready = slv_arready; assign s_if.rvalid = slv_rvalid;
    assign s_if.rdata   = slv_rdata;   assign s_if.rresp  = slv_rresp;
    assign s_if.awready = slv_awready; assign s_if.wready = slv_wready;
    assign s_if.bvalid  = slv_bvalid;  assign s_if.bresp  = slv_bresp;
    assign so_araddr = s_if.araddr; assign so_arvalid = s_if.arvalid; assign so_rready = s_if.rready;
    assign so_awaddr = s_if.awaddr; assign so_awvalid = s_if.awvalid;
    assign so_wdata  = s_if.wdata;  assign so_wstrb = s_if.wstrb; assign so_wvalid = s_if.wvalid;
    assign so_bready = s_if.bready;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk_m(logic ar, logic rv, logic [31:0] rd, logic [1:0] rr,
                                          logic aw, logic w, logic bv, logic [1:0] br);
        return {87'd0, ar, rv, rd, rr, aw, w, bv, br};
    endfunction

    function automatic logic [127:0] pk_s(logic [31:0] ara, logic arv, logic rr, logic [31:0] awa,
                                          logic awv, logic [31:0] wd, logic [3:0] ws, logic wv, logic br);
        return {23'd0, ara, arv, rr, awa, awv, wd, ws, wv, br};
    endfunction

    // transaction-level model: who owns the slave, what kind of transfer, which phases are done
    int own = -1;
    bit rd_kind = 1'b0, ar_seen = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
    int last_w = 1;
    bit hs_ar [2], hs_aw [2], hs_w [2];

    always @(negedge clk) begin : model
        logic        e_ar [2], e_rv [2], e_aw [2], e_w [2], e_bv [2];
        logic [31:0] e_rd [2];
        logic [1:0]  e_rr [2], e_br [2];
        logic [31:0] x_ara, x_awa, x_wd;
        logic [3:0]  x_ws;
        logic        x_arv, x_rr, x_awv, x_wv, x_br;
        int o, w;
        bit r0, r1;
        for (int m = 0; m < 2; m++) begin
            e_ar[m] = 1'b0; e_rv[m] = 1'b0; e_rd[m] = 32'd0; e_rr[m] = 2'd0;
            e_aw[m] = 1'b0; e_w[m] = 1'b0; e_bv[m] = 1'b0; e_br[m] = 2'd0;
        end
        x_ara = 32'd0; x_arv = 1'b0; x_rr = 1'b0; x_awa = 32'd0; x_awv = 1'b0;
        x_wd = 32'd0; x_ws = 4'd0; x_wv = 1'b0; x_br = 1'b0;
        o = own;
        if (!rst && o >= 0) begin
            if (rd_kind && !ar_seen) begin
                x_arv = mst_arvalid[o]; x_ara = mst_araddr[o]; e_ar[o] = slv_arready;
            end else if (rd_kind) begin
                x_rr = mst_rready[o]; e_rv[o] = slv_rvalid; e_rd[o] = slv_rdata; e_rr[o] = slv_rresp;
            end else if (!(aw_seen && w_seen)) begin
                x_awa = mst_awaddr[o]; x_awv = mst_awvalid[o] && !aw_seen; e_aw[o] = slv_awready && !aw_seen;
                x_wd = mst_wdata[o]; x_ws = mst_wstrb[o];
                x_wv = mst_wvalid[o] && !w_seen; e_w[o] = slv_wready && !w_seen;
            end else begin
                x_br = mst_bready[o]; e_bv[o] = slv_bvalid; e_br[o] = slv_bresp;
            end
        end
        for (int m = 0; m < 2; m++) begin
            chk(m == 0 ? "cyc_m0" : "cyc_m1",
                pk_m(mo_arready[m], mo_rvalid[m], mo_rdata[m], mo_rresp[m],
                     mo_awready[m], mo_wready[m], mo_bvalid[m], mo_bresp[m]),
                pk_m(e_ar[m], e_rv[m], e_rd[m], e_rr[m], e_aw[m], e_w[m], e_bv[m], e_br[m]));
            hs_ar[m] = mst_arvalid[m] && mo_arready[m];
            hs_aw[m] = mst_awvalid[m] && mo_awready[m];
            hs_w[m]  = mst_wvalid[m] && mo_wready[m];
        end
        chk("cyc_s",
            pk_s(so_araddr, so_arvalid, so_rready, so_awaddr, so_awvalid, so_wdata, so_wstrb, so_wvalid, so_bready),
            pk_s(x_ara, x_arv, x_rr, x_awa, x_awv, x_wd, x_ws, x_wv, x_br));
        // advance the model to the state that holds after the coming rising edge
        if (rst) begin
            own = -1; last_w = 1; aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
        end else if (o < 0) begin
            r0 = mst_arvalid[0] || mst_awvalid[0];
            r1 = mst_arvalid[1] || mst_awvalid[1];
            w = -1;
`ifdef ARB_LSU_PRIORITY_EN
            if (r1) w = 1; else if (r0) w = 0;
`else
            if (r0 && r1) w = 1 - last_w; else if (r0) w = 0; else if (r1) w = 1;
`endif
            if (w >= 0) begin
                own = w; last_w = w; rd_kind = mst_arvalid[w];
                ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
            end
        end else if (rd_kind && !ar_seen) begin
            if (mst_arvalid[o] && slv_arready) ar_seen = 1'b1;
        end else if (rd_kind) begin
            if (slv_rvalid && mst_rready[o]) own = -1;
        end else if (!(aw_seen && w_seen)) begin
            if (mst_awvalid[o] && slv_awready) aw_seen = 1'b1;
            if (mst_wvalid[o] && slv_wready) w_seen = 1'b1;
        end else begin
            if (slv_bvalid && mst_bready[o]) own = -1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int m = 0; m < 2; m++) begin
            mst_arvalid[m] = 1'b0; mst_awvalid[m] = 1'b0; mst_wvalid[m] = 1'b0;
            mst_rready[m] = 1'b0; mst_bready[m] = 1'b0;
            mst_araddr[m] = 32'd0; mst_awaddr[m] = 32'd0; mst_wdata[m] = 32'd0; mst_wstrb[m] = 4'd0;
        end
        slv_arready = 1'b0; slv_rvalid = 1'b0; slv_awready = 1'b0; slv_wready = 1'b0;
        slv_bvalid = 1'b0; slv_rdata = 32'd0; slv_rresp = 2'd0; slv_bresp = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    int got [4];
    int exp_g [4];
    int n;

    initial begin
        rst = 1'b1;
        clr();
        do_reset();

        // single read from m0
        tick();
        mst_arvalid[0] = 1'b1; mst_araddr[0] = 32'h8000_0000; slv_arready = 1'b1;
        #2 chk("rd_idle_s_arvalid", so_arvalid, 1'b0);
        tick();
        #2 chk("rd_s_arvalid", so_arvalid, 1'b1);
        chk("rd_s_araddr", so_araddr, 32'h8000_0000);
        tick();
        mst_arvalid[0] = 1'b0; slv_rvalid = 1'b1; slv_rdata = 32'h1234_5678; mst_rready[0] = 1'b1;
        #2 chk("rd_m0_rvalid", mo_rvalid[0], 1'b1);
        chk("rd_m0_rdata", mo_rdata[0], 32'h1234_5678);
        chk("rd_m0_rresp", mo_rresp[0], 2'd0);
        chk("rd_m1_rvalid", mo_rvalid[1], 1'b0);
        tick();
        clr();

        // simultaneous reads out of reset, both kept requesting
        do_reset();
        tick();
        mst_arvalid[0] = 1'b1; mst_araddr[0] = 32'h100;
        mst_arvalid[1] = 1'b1; mst_araddr[1] = 32'h200;
        mst_rready[0] = 1'b1; mst_rready[1] = 1'b1; slv_arready = 1'b1; slv_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) got[k] = -1;
`ifdef ARB_LSU_PRIORITY_EN
        exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1;
`else
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`endif
        n = 0;
        #2;
        for (int c = 0; c < 40 && n < 4; c++) begin
            for (int m = 0; m < 2; m++)
                if (n < 4 && mst_arvalid[m] && mo_arready[m]) begin
                    got[n] = m; n++;
                end
            tick();
            #2;
        end
        for (int k = 0; k < 4; k++) chk($sformatf("tie_grant_%0d", k), got[k], exp_g[k]);

        // m1 write with AW and W accepted in different cycles
        do_reset();
        tick();
        mst_awvalid[1] = 1'b1; mst_awaddr[1] = 32'ha000_03f8;
        mst_wvalid[1] = 1'b1; mst_wdata[1] = 32'h41; mst_wstrb[1] = 4'h1; mst_bready[1] = 1'b1;
        slv_bvalid = 1'b1;
        #2 chk("wr_c0_awvalid", so_awvalid, 1'b0);
        tick();
        #2 chk("wr_c1_awvalid", so_awvalid, 1'b1);
        chk("wr_c1_awaddr", so_awaddr, 32'ha000_03f8);
        chk("wr_c1_bvalid", mo_bvalid[1], 1'b0);
        tick();
        slv_awready = 1'b1;
        #2 chk("wr_c2_awready", mo_awready[1], 1'b1);
        tick();
        #2 chk("wr_c3_awvalid_masked", so_awvalid, 1'b0);
        chk("wr_c3_awready_masked", mo_awready[1], 1'b0);
        tick();
        slv_wready = 1'b1;
        #2 chk("wr_c4_wvalid", so_wvalid, 1'b1);
        chk("wr_c4_wdata", {so_wstrb, so_wdata}, {4'h1, 32'h41});
        chk("wr_c4_bvalid", mo_bvalid[1], 1'b0);
        tick();
        mst_awvalid[1] = 1'b0; mst_wvalid[1] = 1'b0;
        #2 chk("wr_c5_bvalid", mo_bvalid[1], 1'b1);
        chk("wr_c5_bresp", mo_bresp[1], 2'd0);
        chk("wr_c5_bready", so_bready, 1'b1);

        // no preemption while m0 waits for read data
        do_reset();
        tick();
        mst_arvalid[0] = 1'b1; mst_araddr[0] = 32'h1000; slv_arready = 1'b1;
        mst_rready[0] = 1'b1; mst_rready[1] = 1'b1;
        tick();
        tick();
        mst_arvalid[0] = 1'b0; mst_arvalid[1] = 1'b1; mst_araddr[1] = 32'h2000;
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("np_wait_%0d", i), mo_arready[1], 1'b0);
            tick();
        end
        slv_rvalid = 1'b1;
        #2 chk("np_m0_rvalid", mo_rvalid[0], 1'b1);
        chk("np_hs_m1_arready", mo_arready[1], 1'b0);
        tick();
        slv_rvalid = 1'b0;
        #2 chk("np_idle_gap", so_arvalid, 1'b0);
        tick();
        #2 chk("np_m1_granted", {mo_arready[1], so_arvalid, so_araddr}, {1'b1, 1'b1, 32'h2000});

        // same master asks for read and write together
        do_reset();
        tick();
        mst_arvalid[0] = 1'b1; mst_awvalid[0] = 1'b1; mst_wvalid[0] = 1'b1;
        mst_rready[0] = 1'b1; mst_bready[0] = 1'b1;
        slv_arready = 1'b1; slv_awready = 1'b1; slv_wready = 1'b1; slv_rvalid = 1'b1; slv_bvalid = 1'b1;
        tick();
        #2 chk("rbw_read_first", {so_arvalid, so_awvalid}, 2'b10);
        tick();
        mst_arvalid[0] = 1'b0;
        tick();
        tick();
        #2 chk("rbw_write_next", {so_arvalid, so_awvalid}, 2'b01);

        // reset in the middle of a write after the AW handshake
        do_reset();
        tick();
        mst_awvalid[0] = 1'b1; mst_awaddr[0] = 32'h40; mst_wvalid[0] = 1'b1; mst_wdata[0] = 32'h5;
        mst_wstrb[0] = 4'hf; slv_awready = 1'b1;
        tick();
        tick();
        mst_awvalid[0] = 1'b0;
        #2 chk("mr_pre_wvalid", so_wvalid, 1'b1);
        rst = 1'b1;
        #1 chk("mr_outputs_zero", {so_wvalid, so_awvalid, mo_wready[0], mo_awready[0]}, 4'b0000);
        do_reset();
        tick();
        mst_arvalid[0] = 1'b1; mst_araddr[0] = 32'h3000; slv_arready = 1'b1;
        slv_rvalid = 1'b1; slv_rdata = 32'hcafe_f00d; mst_rready[0] = 1'b1;
        tick();
        #2 chk("mr_read_ar", {so_arvalid, so_araddr}, {1'b1, 32'h3000});
        tick();
        mst_arvalid[0] = 1'b0;
        #2 chk("mr_read_r", {mo_rvalid[0], mo_rdata[0]}, {1'b1, 32'hcafe_f00d});
        tick();
        mst_awvalid[0] = 1'b1; mst_awaddr[0] = 32'h44; mst_wvalid[0] = 1'b1;
        tick();
        tick();
        #2 chk("mr_aw_done_clear", so_awvalid, 1'b1);

        // random traffic checked by the model every cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if (hs_ar[m]) mst_arvalid[m] = 1'b0;
                if (hs_aw[m]) mst_awvalid[m] = 1'b0;
                if (hs_w[m])  mst_wvalid[m] = 1'b0;
                if (!mst_arvalid[m] && $urandom_range(3) == 0) begin
                    mst_arvalid[m] = 1'b1; mst_araddr[m] = $urandom;
                end
                if (!mst_awvalid[m] && !mst_wvalid[m] && $urandom_range(4) == 0) begin
                    mst_awvalid[m] = 1'b1; mst_awaddr[m] = $urandom;
                    mst_wvalid[m] = 1'b1; mst_wdata[m] = $urandom; mst_wstrb[m] = 4'($urandom_range(15));
                end
                mst_rready[m] = 1'($urandom_range(1));
                mst_bready[m] = 1'($urandom_range(1));
            end
            slv_arready = 1'($urandom_range(1)); slv_awready = 1'($urandom_range(1));
            slv_wready = 1'($urandom_range(1)); slv_rvalid = 1'($urandom_range(1));
            slv_bvalid = 1'($urandom_range(1)); slv_rdata = $urandom;
            slv_rresp = 2'($urandom_range(3)); slv_bresp = 2'($urandom_range(3));
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
